// File: rtl/wb_sched.sv
// Writeback scheduler: four one-entry holding registers (LSU, MDV, CSR, ALU) drained
// one per cycle to the GPR write port by a fixed-priority arbiter with starvation ageing.
// The CSR unit's GPR destination/data come in on csr_rd_waddr_i/csr_rd_wdata_i; csr_waddr_i/csr_wdata_i carry the CSR address/data.
module wb_sched #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned CSR_AW       = 32,
    parameter int unsigned ID_W         = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic [ADDR_W-1:0] lsu_waddr_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    input  logic [ID_W-1:0]   lsu_id_i,
    input  logic              mdv_valid_i,
    output logic              mdv_ready_o,
    input  logic [ADDR_W-1:0] mdv_waddr_i,
    input  logic [DATA_W-1:0] mdv_wdata_i,
    input  logic [ID_W-1:0]   mdv_id_i,
    input  logic              csr_valid_i,
    output logic              csr_ready_o,
    input  logic [ADDR_W-1:0] csr_rd_waddr_i,
    input  logic [DATA_W-1:0] csr_rd_wdata_i,
    input  logic              csr_rd_we_i,
    input  logic [CSR_AW-1:0] csr_waddr_i,
    input  logic [DATA_W-1:0] csr_wdata_i,
    input  logic              alu_valid_i,
    output logic              alu_ready_o,
    input  logic [ADDR_W-1:0] alu_waddr_i,
    input  logic [DATA_W-1:0] alu_wdata_i,
    input  logic              flush_i,
    output logic              reg_we_o,
    output logic [ADDR_W-1:0] reg_waddr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              csr_we_o,
    output logic [CSR_AW-1:0] csr_waddr_o,
    output logic [DATA_W-1:0] csr_wdata_o,
    output logic              commit_valid_o,
    output logic [ID_W-1:0]   commit_id_o,
    output logic              busy_o
);

    localparam int unsigned NS    = 4;
    localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned LSU   = 0;
    localparam int unsigned MDV   = 1;
    localparam int unsigned CSR   = 2;
    localparam int unsigned ALU   = 3;

    logic [NS-1:0]     in_valid;
    logic [NS-1:0]     hv;
    logic [NS-1:0]     starved;
    logic [NS-1:0]     pick;
    logic [NS-1:0]     grant;
    logic [NS-1:0]     ready;
    logic [NS-1:0]     load;
    logic [ADDR_W-1:0] in_waddr [NS];
    logic [DATA_W-1:0] in_wdata [NS];
    logic [ADDR_W-1:0] h_waddr  [NS];
    logic [DATA_W-1:0] h_wdata  [NS];
    logic [AGE_W-1:0]  age      [NS];
    logic [ID_W-1:0]   h_lsu_id;
    logic [ID_W-1:0]   h_mdv_id;
    logic              h_rd_we;
    logic [CSR_AW-1:0] h_csr_addr;
    logic [DATA_W-1:0] h_csr_data;
    logic [ADDR_W-1:0] sel_waddr;
    logic [DATA_W-1:0] sel_wdata;

    assign in_valid       = {alu_valid_i, csr_valid_i, mdv_valid_i, lsu_valid_i};
    assign in_waddr[LSU]  = lsu_waddr_i;
    assign in_waddr[MDV]  = mdv_waddr_i;
    assign in_waddr[CSR]  = csr_rd_waddr_i;
    assign in_waddr[ALU]  = alu_waddr_i;
    assign in_wdata[LSU]  = lsu_wdata_i;
    assign in_wdata[MDV]  = mdv_wdata_i;
    assign in_wdata[CSR]  = csr_rd_wdata_i;
    assign in_wdata[ALU]  = alu_wdata_i;

    // Starved holds win first; within a set, bit 0 (LSU) has highest priority.
    always_comb begin
        starved = '0;
        for (int i = 0; i < NS; i++) begin
            starved[i] = hv[i] && (age[i] == AGE_W'(STARVE_LIMIT));
        end
        pick  = (|starved) ? starved : hv;
        grant = flush_i ? '0 : (pick & (~pick + NS'(1)));
    end

    assign ready       = flush_i ? '0 : (~hv | grant);
    assign load        = in_valid & ready;
    assign lsu_ready_o = ready[LSU];
    assign mdv_ready_o = ready[MDV];
    assign csr_ready_o = ready[CSR];
    assign alu_ready_o = ready[ALU];
    assign busy_o      = |hv;

    always_comb begin
        sel_waddr = '0;
        sel_wdata = '0;
        for (int i = 0; i < NS; i++) begin
            if (grant[i]) begin
                sel_waddr = h_waddr[i];
                sel_wdata = h_wdata[i];
            end
        end
        reg_waddr_o    = sel_waddr;
        reg_wdata_o    = sel_wdata;
        // x0 and CSR-without-rd still retire, just without a GPR write.
        reg_we_o       = (|grant) && (sel_waddr != '0) && !(grant[CSR] && !h_rd_we);
        csr_we_o       = grant[CSR];
        csr_waddr_o    = grant[CSR] ? h_csr_addr : '0;
        csr_wdata_o    = grant[CSR] ? h_csr_data : '0;
        commit_valid_o = grant[LSU] || grant[MDV];
        commit_id_o    = grant[LSU] ? h_lsu_id : (grant[MDV] ? h_mdv_id : '0);
    end

    // Holding registers and ages; flush beats load, load beats grant-drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hv         <= '0;
            h_lsu_id   <= '0;
            h_mdv_id   <= '0;
            h_rd_we    <= 1'b0;
            h_csr_addr <= '0;
            h_csr_data <= '0;
            for (int i = 0; i < NS; i++) begin
                age[i]     <= '0;
                h_waddr[i] <= '0;
                h_wdata[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (flush_i) begin
                    hv[i]  <= 1'b0;
                    age[i] <= '0;
                end else if (load[i]) begin
                    hv[i]      <= 1'b1;
                    age[i]     <= '0;
                    h_waddr[i] <= in_waddr[i];
                    h_wdata[i] <= in_wdata[i];
                end else if (grant[i] || !hv[i]) begin
                    hv[i]  <= 1'b0;
                    age[i] <= '0;
                end else if (age[i] != AGE_W'(STARVE_LIMIT)) begin
                    age[i] <= AGE_W'(age[i] + AGE_W'(1));
                end
            end
            if (load[LSU]) h_lsu_id <= lsu_id_i;
            if (load[MDV]) h_mdv_id <= mdv_id_i;
            if (load[CSR]) begin
                h_rd_we    <= csr_rd_we_i;
                h_csr_addr <= csr_waddr_i;
                h_csr_data <= csr_wdata_i;
            end
        end
    end

endmodule

// File: tb/tb_wb_sched.sv
// Scoreboard bench for wb_sched: expected writeback events (with their cycle) are
// queued as stimulus is driven and matched against DUT output at each falling edge.
module tb_wb_sched;

    typedef struct {
        int          cyc;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        cwe;
        logic [31:0] ca;
        logic [31:0] cd;
        logic        cv;
        logic [1:0]  cid;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_valid = 1'b0, mdv_valid = 1'b0, csr_valid = 1'b0, alu_valid = 1'b0;
    logic        lsu_ready, mdv_ready, csr_ready, alu_ready;
    logic [4:0]  lsu_waddr = '0, mdv_waddr = '0, csr_rd_waddr = '0, alu_waddr = '0;
    logic [31:0] lsu_wdata = '0, mdv_wdata = '0, csr_rd_wdata = '0, alu_wdata = '0;
    logic [1:0]  lsu_id = '0, mdv_id = '0;
    logic        csr_rd_we = 1'b0;
    logic [31:0] csr_waddr = '0, csr_wdata = '0;
    logic        flush = 1'b0;
    logic        reg_we, csr_we, commit_valid, busy;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata, csr_waddr_q, csr_wdata_q;
    logic [1:0]  commit_id;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sb[$];

    wb_sched dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_waddr_i(lsu_waddr),
        .lsu_wdata_i(lsu_wdata), .lsu_id_i(lsu_id),
        .mdv_valid_i(mdv_valid), .mdv_ready_o(mdv_ready), .mdv_waddr_i(mdv_waddr),
        .mdv_wdata_i(mdv_wdata), .mdv_id_i(mdv_id),
        .csr_valid_i(csr_valid), .csr_ready_o(csr_ready), .csr_rd_waddr_i(csr_rd_waddr),
        .csr_rd_wdata_i(csr_rd_wdata), .csr_rd_we_i(csr_rd_we),
        .csr_waddr_i(csr_waddr), .csr_wdata_i(csr_wdata),
        .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_waddr_i(alu_waddr),
        .alu_wdata_i(alu_wdata),
        .flush_i(flush),
        .reg_we_o(reg_we), .reg_waddr_o(reg_waddr), .reg_wdata_o(reg_wdata),
        .csr_we_o(csr_we), .csr_waddr_o(csr_waddr_q), .csr_wdata_o(csr_wdata_q),
        .commit_valid_o(commit_valid), .commit_id_o(commit_id), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic void push(input int c, input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic cwe, input logic [31:0] ca,
                                 input logic [31:0] cd, input logic cv, input logic [1:0] cid);
        exp_t e;
        e.cyc = c; e.we = we; e.wa = wa; e.wd = wd; e.cwe = cwe;
        e.ca = ca; e.cd = cd; e.cv = cv; e.cid = cid;
        sb.push_back(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        lsu_valid = 1'b0; mdv_valid = 1'b0; csr_valid = 1'b0; alu_valid = 1'b0;
        flush = 1'b0;
    endtask

    // Any retirement event must match the head of the scoreboard; idle cycles must show zeros.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (reg_we || csr_we || commit_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", {reg_we, csr_we, commit_valid}, 3'b000);
                end else begin
                    e = sb.pop_front();
                    chk("ev_cycle", 64'(cyc), 64'(e.cyc));
                    chk("ev_reg_we", reg_we, e.we);
                    chk("ev_waddr", reg_waddr, e.wa);
                    chk("ev_wdata", reg_wdata, e.wd);
                    chk("ev_csr_we", csr_we, e.cwe);
                    chk("ev_csr_addr", csr_waddr_q, e.ca);
                    chk("ev_csr_data", csr_wdata_q, e.cd);
                    chk("ev_commit", commit_valid, e.cv);
                    chk("ev_commit_id", commit_id, e.cid);
                end
            end else begin
                chk("idle_gpr", {reg_waddr, reg_wdata}, '0);
                chk("idle_csr", {csr_waddr_q, csr_wdata_q}, '0);
                chk("idle_cid", commit_id, '0);
            end
        end
    end

    initial begin
        int c;
        int k;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_writes", {reg_we, csr_we, commit_valid}, 3'b000);
        chk("rst_bus", {reg_waddr, reg_wdata, commit_id}, '0);
        chk("rst_ready", {lsu_ready, mdv_ready, csr_ready, alu_ready}, 4'b1111);
        #10 rst_n = 1'b1;
        step();

        // Single ALU result
        c = cyc;
        alu_valid = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'h1234;
        #2 chk("t1_alu_ready", alu_ready, 1);
        push(c + 1, 1, 5, 32'h1234, 0, 0, 0, 0, 0);
        step(); clear_inputs();
        step(); #2 chk("t1_busy", busy, 0);

        // LSU beats ALU; LSU carries a commit
        step(); c = cyc;
        lsu_valid = 1'b1; lsu_waddr = 5'd3; lsu_wdata = 32'hA3; lsu_id = 2'd2;
        alu_valid = 1'b1; alu_waddr = 5'd4; alu_wdata = 32'hB4;
        push(c + 1, 1, 3, 32'hA3, 0, 0, 0, 1, 2);
        push(c + 2, 1, 4, 32'hB4, 0, 0, 0, 0, 0);
        step(); clear_inputs();
        step(); step();

        // Starvation: LSU streams, ALU offered once and force-granted at cycle 5
        step(); c = cyc;
        alu_valid = 1'b1; alu_waddr = 5'd9; alu_wdata = 32'hA9;
        for (int i = 0; i < 4; i++) push(c + 1 + i, 1, 5'(10 + i), 32'h100 + i, 0, 0, 0, 1, 2'(i));
        push(c + 5, 1, 9, 32'hA9, 0, 0, 0, 0, 0);
        for (int i = 4; i < 8; i++) push(c + 2 + i, 1, 5'(10 + i), 32'h100 + i, 0, 0, 0, 1, 2'(i));
        k = 0;
        for (int t = 0; t < 12 && k < 8; t++) begin
            lsu_valid = 1'b1; lsu_waddr = 5'(10 + k); lsu_wdata = 32'h100 + k; lsu_id = 2'(k);
            #2 chk("t3_lsu_ready", lsu_ready, (cyc == c + 5) ? 1'b0 : 1'b1);
            if (lsu_ready) k++;
            step();
            alu_valid = 1'b0;
        end
        clear_inputs();
        step(); step(); step();

        // CSR with and without rd write
        c = cyc;
        csr_valid = 1'b1; csr_rd_waddr = 5'd7; csr_rd_wdata = 32'hA; csr_rd_we = 1'b1;
        csr_waddr = 32'h300; csr_wdata = 32'h8;
        push(c + 1, 1, 7, 32'hA, 1, 32'h300, 32'h8, 0, 0);
        step(); clear_inputs(); step();
        c = cyc;
        csr_valid = 1'b1; csr_rd_we = 1'b0;
        push(c + 1, 0, 7, 32'hA, 1, 32'h300, 32'h8, 0, 0);
        step(); clear_inputs(); step();

        // MDV to x0: commit without GPR write
        c = cyc;
        mdv_valid = 1'b1; mdv_waddr = 5'd0; mdv_wdata = 32'h55; mdv_id = 2'd1;
        push(c + 1, 0, 0, 32'h55, 0, 0, 0, 1, 1);
        step(); clear_inputs(); step();

        // Flush with all four slots full
        lsu_valid = 1'b1; lsu_waddr = 5'd1; mdv_valid = 1'b1; mdv_waddr = 5'd2;
        csr_valid = 1'b1; csr_rd_waddr = 5'd3; csr_rd_we = 1'b1; alu_valid = 1'b1; alu_waddr = 5'd4;
        step(); clear_inputs();
        flush = 1'b1; alu_valid = 1'b1; alu_waddr = 5'd6; alu_wdata = 32'hDEAD;
        #2 chk("flush_ready", {lsu_ready, mdv_ready, csr_ready, alu_ready}, 4'b0000);
        chk("flush_busy", busy, 1);
        chk("flush_writes", {reg_we, csr_we, commit_valid}, 3'b000);
        step(); clear_inputs();
        #2 chk("post_flush_busy", busy, 0);
        chk("post_flush_ready", {lsu_ready, mdv_ready, csr_ready, alu_ready}, 4'b1111);
        step(); step();

        // Asynchronous reset with pending entries
        alu_valid = 1'b1; alu_waddr = 5'd8; alu_wdata = 32'h88;
        mdv_valid = 1'b1; mdv_waddr = 5'd9; mdv_id = 2'd3;
        step(); clear_inputs();
        #1 rst_n = 1'b0;
        #1 chk("arst_busy", busy, 0);
        chk("arst_writes", {reg_we, csr_we, commit_valid}, 3'b000);
        chk("arst_ready", {lsu_ready, mdv_ready, csr_ready, alu_ready}, 4'b1111);
        #3 rst_n = 1'b1;
        step(); step(); step();

        chk("sb_drained", 64'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
